uart_reg_loader: RTL and testbench

UART_REG_LOADER -- requirements
Module: uart_reg_loader

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_byte.sv | 111 +++++++++++
 rtl/uart_reg_loader.sv | 105 ++++++++++
 tb/tb_uart_reg_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, bit counting and frame sizing.
package uart_pkg;

  localparam int unsigned BYTE_BITS = 8;
  localparam int unsigned BIT_CNT_W = 3;

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Bytes in one register-load frame: one address byte plus the data bytes.
  function automatic int unsigned frame_bytes(input int unsigned data_width);
    return 1 + data_width / BYTE_BITS;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with input synchronizer.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       rx_active
);
  import uart_pkg::*;

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

  logic            rx_m, rx_s;
  rx_state_t       state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  bit_cnt_t        bitn, bitn_n;
  logic [7:0]      shreg, shreg_n;
  logic            valid_n, err_n;
  logic            armed, armed_n;

  // Two-flop synchronizer, idle-high reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bitn       <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      armed      <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bitn       <= bitn_n;
      shreg      <= shreg_n;
      byte_valid <= valid_n;
      byte_err   <= err_n;
      armed      <= armed_n;
    end
  end

  // Next-state logic. After a framing error the line may still be low (break);
  // the receiver is re-armed only once the line has been seen high again, so a
  // held-low stop bit is not misread as a new start bit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bitn_n  = bitn;
    shreg_n = shreg;
    valid_n = 1'b0;
    err_n   = 1'b0;
    armed_n = armed | rx_s;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (!rx_s && armed) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = RX_DATA;
            bitn_n  = '0;
          end else begin
            state_n = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          if (bitn == bit_cnt_t'(BYTE_BITS - 1)) state_n = RX_STOP;
          else                                   bitn_n  = bitn + bit_cnt_t'(1);
        end
      end
      RX_STOP: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          if (rx_s) begin
            valid_n = 1'b1;
          end else begin
            err_n   = 1'b1;
            armed_n = 1'b0;
          end
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign byte_data = shreg;
  assign rx_active = (state != RX_IDLE);

endmodule

// File: rtl/uart_reg_loader.sv
// Assembles UART frames (address byte + data bytes, LS first) into register writes.
module uart_reg_loader #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  WE3,
  output logic [ADDR_WIDTH-1:0] A3,
  output logic [DATA_WIDTH-1:0] WD3,
  output logic                  busy,
  output logic                  frame_err
);
  import uart_pkg::*;

  localparam int unsigned NBYTES   = frame_bytes(DATA_WIDTH);
  localparam int unsigned IW       = $clog2(NBYTES);
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TW       = $clog2(TO_LIMIT + 1);

  logic [7:0]            byte_data;
  logic                  byte_valid, byte_err, rx_active;
  logic [IW-1:0]         idx, slot;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_acc, data_next;
  logic [TW-1:0]         to_cnt;
  logic                  timeout, fin, last;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .rx_active (rx_active)
  );

  // Merge the incoming data byte into its slot of the accumulated word.
  always_comb begin
    slot      = idx - IW'(1);
    data_next = data_acc;
    if (idx != '0) data_next[{slot, 3'b000} +: 8] = byte_data;
  end

  assign last    = (idx == IW'(NBYTES - 1));
  assign timeout = (idx != '0) && !rx_active && (to_cnt == TW'(TO_LIMIT));

  // Mid-frame idle counter; only counts while the line is idle, saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    to_cnt <= '0;
    else if (idx == '0 || rx_active) to_cnt <= '0;
    else if (to_cnt != TW'(TO_LIMIT)) to_cnt <= to_cnt + TW'(1);
  end

  // Frame assembly, write issue and discard handling. fin marks frame
  // completion even for address 0 so busy ends there without a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      addr_q    <= '0;
      data_acc  <= '0;
      WE3       <= 1'b0;
      A3        <= '0;
      WD3       <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      fin       <= 1'b0;
    end else begin
      WE3       <= 1'b0;
      frame_err <= 1'b0;
      fin       <= 1'b0;
      if (fin || frame_err) busy <= 1'b0;
      if (byte_err || timeout) begin
        idx       <= '0;
        frame_err <= 1'b1;
      end else if (byte_valid) begin
        busy <= 1'b1;
        if (idx == '0) begin
          addr_q <= ADDR_WIDTH'(byte_data);
          idx    <= IW'(1);
        end else begin
          data_acc <= data_next;
          if (last) begin
            idx <= '0;
            fin <= 1'b1;
            if (addr_q != '0) begin
              WE3 <= 1'b1;
              A3  <= addr_q;
              WD3 <= data_next;
            end
          end else begin
            idx <= idx + IW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_loader.sv
// Self-checking bench for uart_reg_loader with a write scoreboard.
module tb_uart_reg_loader;

  localparam int unsigned CPB = 8;
  localparam int unsigned TOB = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx = 1'b1;
  logic          WE3;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic          busy;
  logic          frame_err;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t         sb[$];
  wr_t         exp_wr;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned err_seen = 0;
  logic        we_prev  = 1'b0;

  uart_reg_loader #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .WE3      (WE3),
    .A3       (A3),
    .WD3      (WD3),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Output monitor: pops the scoreboard on each write, counts error pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_err) err_seen++;
      if (WE3) begin
        if (sb.size() == 0) begin
          check("we_unexpected", 64'(WE3), 64'd0);
        end else begin
          exp_wr = sb.pop_front();
          check("A3", 64'(A3), 64'(exp_wr.a));
          check("WD3", 64'(WD3), 64'(exp_wr.d));
          check("busy_at_we", 64'(busy), 64'd1);
        end
      end
      if (we_prev && WE3) check("we_width", 64'(WE3), 64'd0);
      we_prev = WE3;
    end else begin
      we_prev = 1'b0;
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [DW-1:0] d);
    wr_t w;
    if (a[AW-1:0] != '0) begin
      w.a = a[AW-1:0];
      w.d = d;
      sb.push_back(w);
    end
    send_byte(a, 1'b1);
    for (int i = 0; i < DW / 8; i++) send_byte(d[8*i +: 8], 1'b1);
  endtask

  initial begin
    // reset state
    idle(3);
    check("rst_WE3", 64'(WE3), 64'd0);
    check("rst_A3", 64'(A3), 64'd0);
    check("rst_WD3", 64'(WD3), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ferr", 64'(frame_err), 64'd0);
    reset = 1'b1;
    idle(4);

    // basic write
    send_frame(8'h05, 32'h1234_5678);
    idle(20);
    check("basic_sb", 64'(sb.size()), 64'd0);
    check("basic_err", 64'(err_seen), 64'd0);
    check("basic_busy", 64'(busy), 64'd0);

    // address 0 frame then back-to-back write to 31
    send_frame(8'h00, 32'hDEAD_BEEF);
    w_push(5'h1F, 32'h0000_0001);
    send_byte(8'h1F, 1'b1);
    check("hold_A3", 64'(A3), 64'h05);
    check("hold_WD3", 64'(WD3), 64'h1234_5678);
    check("busy_mid", 64'(busy), 64'd1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(20);
    check("b2b_sb", 64'(sb.size()), 64'd0);
    check("b2b_err", 64'(err_seen), 64'd0);

    // framing error mid-frame, then recovery
    send_byte(8'h03, 1'b1);
    send_byte(8'hAA, 1'b0);
    idle(3 * CPB);
    check("ferr_count", 64'(err_seen), 64'd1);
    check("ferr_busy", 64'(busy), 64'd0);
    send_frame(8'h03, 32'h4433_2211);
    idle(20);
    check("ferr_rec_sb", 64'(sb.size()), 64'd0);
    check("ferr_rec_err", 64'(err_seen), 64'd1);

    // inter-byte timeout
    send_byte(8'h07, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    check("to_busy_pre", 64'(busy), 64'd1);
    idle(40);
    check("to_count", 64'(err_seen), 64'd2);
    check("to_busy", 64'(busy), 64'd0);

    // start-bit glitch
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(4);
    check("glitch_busy_mid", 64'(busy), 64'd0);
    idle(26);
    check("glitch_busy", 64'(busy), 64'd0);
    check("glitch_err", 64'(err_seen), 64'd2);

    // reset mid-frame; leftover bytes form a partial frame that times out
    send_byte(8'h09, 1'b1);
    send_byte(8'hAB, 1'b1);
    reset = 1'b0;
    idle(2);
    check("mrst_WE3", 64'(WE3), 64'd0);
    check("mrst_A3", 64'(A3), 64'd0);
    check("mrst_WD3", 64'(WD3), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_ferr", 64'(frame_err), 64'd0);
    reset = 1'b1;
    idle(2);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'h01, 1'b1);
    idle(40);
    check("mrst_tail_err", 64'(err_seen), 64'd3);
    check("mrst_tail_busy", 64'(busy), 64'd0);

    // upper address bits ignored
    send_frame(8'hFC, 32'hA5A5_0F0F);
    idle(20);
    check("addr_trunc_sb", 64'(sb.size()), 64'd0);
    check("final_err", 64'(err_seen), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  task automatic w_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    sb.push_back(w);
  endtask

endmodule
